risc_fetch_unit: RTL
====================

// Module: risc_fetch_unit
// PURPOSE
//  Instruction fetch front end for the 32-bit RISC core. Sits directly upstream of decode/execute.
//  Keeps the program counter and issues in-order reads to instruction memory.
//  Buffers returned words in a prefetch queue and hands them to execute over a valid/ready port.
//  Execute redirects the PC here on a taken BRA.
// PARAMETERS
//  WIDTH     32  instruction/data word width
//  ADDRSIZE  12  PC / memory address width (4096-word space)
//  DEPTH     4   prefetch queue entries; also the limit on queued + outstanding reads (power of 2, >=2)
// PORTS
//  clk          in   1         core clock; all logic on rising edge
//  reset        in   1         synchronous, active-high reset
//  mem_req      out  1         read request to instruction memory
//  mem_addr     out  ADDRSIZE  read address; valid while mem_req=1
//  mem_gnt      in   1         memory accepts the request this cycle (handshake: mem_req & mem_gnt)
//  mem_rvalid   in   1         read data returned; in order, >=1 cycle after grant
//  mem_rdata    in   WIDTH     returned instruction word
//  redirect     in   1         taken-branch flush from execute
//  redirect_pc  in   ADDRSIZE  new fetch address (the BRA DST field)
//  ir_valid     out  1         queue head holds a valid instruction
//  ir_ready     in   1         execute consumes the head (pop on ir_valid & ir_ready)
//  ir           out  WIDTH     head instruction word
//  ir_pc        out  ADDRSIZE  address of the head instruction
//  halted       out  1         fetch stopped on HLT (opcode 4'b1001); see CONFIGURATION
// BEHAVIOUR
//  - Reset: pc=0, queue empty, outstanding=0, stale=0; mem_req=0, ir_valid=0, halted=0.
//    Reset mid-operation abandons all in-flight reads. Memory shares the same reset and returns no post-reset data for pre-reset requests.
//  - Issue: mem_req=1 when !reset & !redirect & !halted & (count+outstanding) < DEPTH; mem_addr=pc.
//    On grant: pc<=pc+1 (wraps 12'hFFF->12'h000), outstanding++.
//  - Return: on mem_rvalid, outstanding--.
//    If stale>0: drop the word, stale--.
//    Otherwise enqueue {rdata, addr}. The address is tracked by a separate return pointer that increments on each kept word.
//  - Queue: mem_rvalid is never dropped for lack of space; the credit rule guarantees room.
//    Simultaneous enqueue and pop are both allowed, including when full (pop frees the slot).
//    ir/ir_pc are driven combinationally from the head; ir is don't-care when !ir_valid.
//  - Latency: data returned in cycle N is visible as ir_valid in cycle N+1. Fetch-to-execute minimum is 2 cycles after grant.
//  - Redirect (priority over everything):
//    * queue cleared; a same-cycle pop is ignored
//    * pc<=redirect_pc; return pointer <= redirect_pc; mem_req=0 that cycle
//    * stale <= outstanding + (grant this cycle ? 1 : 0) - (rvalid this cycle ? 1 : 0), computed in the same update
//    * halted<=0
//    Issue resumes the next cycle. A redirect while stale>0 adds to the stale count.
//  - Invariant: count+outstanding <= DEPTH at all times; stale <= outstanding.
// CONFIGURATION
//  FETCH_HALT_DETECT_EN defined:
//    - When a non-stale word with rdata[31:28]==4'b1001 is enqueued, halted<=1 next cycle and issuing stops.
//    - Words returned after the HLT for reads already in flight are dropped: stale is set to the remaining outstanding.
//    - The HLT word itself is enqueued and popped normally. halted holds until redirect or reset.
//  FETCH_HALT_DETECT_EN undefined:
//    - halted is tied to 0; HLT is fetched like any other word and fetching continues sequentially.
// TESTING
//  1 Reset, mem_gnt=1, 1-cycle memory, ir_ready=1 -> mem_addr 0,1,2,...
//    ir_pc 0,1,2 with matching words; one instruction per cycle after a 2-cycle fill.
//  2 ir_ready=0, mem_gnt=1 -> exactly DEPTH=4 grants, then mem_req=0.
//    ir_ready=1 for one cycle -> exactly one new request issued.
//  3 Redirect to 12'h200 with 2 reads outstanding -> those 2 returns dropped.
//    Next ir_pc=12'h200; no word from the old stream reaches ir.
//  4 redirect_pc=12'hFFE, straight-line code -> ir_pc 12'hFFE, 12'hFFF, 12'h000.
//  5 FETCH_HALT_DETECT_EN, memory word 3 = 32'h9000_0000 -> ir_pc 0..3 delivered, halted=1, no further mem_req.
//    Redirect to 12'h010 -> halted=0, fetch resumes at 12'h010.
//  6 Reset asserted with 3 reads outstanding and queue non-empty -> next cycle ir_valid=0, mem_addr=0.
//    First delivered ir_pc=0.

Source files
------------

// File: rtl/risc_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// risc_fetch_unit_if
// Bundles the fetch unit's memory read port, the redirect input from execute,
// and the valid/ready instruction port towards decode/execute.
//   master : the fetch unit side (drives mem_req/mem_addr, ir_*, halted)
//   slave  : the environment side (instruction memory + execute stage)
// Signals:
//   mem_req, mem_addr      read request / address to instruction memory
//   mem_gnt                memory accepts the request this cycle
//   mem_rvalid, mem_rdata  in-order read return
//   redirect, redirect_pc  taken-branch flush and new fetch address
//   ir_valid, ir_ready     head-of-queue handshake (pop on valid & ready)
//   ir, ir_pc              head instruction word and its address
//   halted                 fetch stopped on HLT
// -----------------------------------------------------------------------------
interface risc_fetch_unit_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDRSIZE = 12
);
    logic                mem_req;
    logic [ADDRSIZE-1:0] mem_addr;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [WIDTH-1:0]    mem_rdata;
    logic                redirect;
    logic [ADDRSIZE-1:0] redirect_pc;
    logic                ir_valid;
    logic                ir_ready;
    logic [WIDTH-1:0]    ir;
    logic [ADDRSIZE-1:0] ir_pc;
    logic                halted;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  redirect, redirect_pc,
        output ir_valid,
        input  ir_ready,
        output ir, ir_pc, halted
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        output redirect, redirect_pc,
        input  ir_valid,
        output ir_ready,
        input  ir, ir_pc, halted
    );
endinterface

// File: rtl/risc_fetch_unit.sv
// -----------------------------------------------------------------------------
// risc_fetch_unit
// Instruction fetch front end: holds the PC, issues in-order reads to
// instruction memory, buffers returned words in a DEPTH-entry prefetch queue
// and presents the head to execute over a valid/ready port. A redirect from
// execute flushes the queue and marks in-flight reads as stale.
// Ports:
//   clk    core clock, rising edge
//   reset  synchronous, active-high
//   bus    risc_fetch_unit_if.master (memory port, redirect, ir port, halted)
// Optional feature:
//   FETCH_HALT_DETECT_EN  when defined, a kept word with opcode 4'b1001 (HLT)
//                         stops issuing and drops the reads still in flight;
//                         otherwise halted is tied to 0.
// -----------------------------------------------------------------------------
module risc_fetch_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDRSIZE = 12,
    parameter int unsigned DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    risc_fetch_unit_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0]    q_data [DEPTH];
    logic [ADDRSIZE-1:0] q_pc   [DEPTH];

    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d, outst_q, outst_d, stale_q, stale_d;
    logic [ADDRSIZE-1:0] pc_q, pc_d, ret_pc_q, ret_pc_d;

    logic credit_ok, grant, keep, enq, pop;

`ifdef FETCH_HALT_DETECT_EN
    logic halted_q, halted_d, is_hlt;
    assign is_hlt = keep && (bus.mem_rdata[WIDTH-1 -: 4] == 4'b1001);
`else
    logic halted_q;
    assign halted_q = 1'b0;
`endif

    // Credit counts both buffered words and reads still in flight, so every
    // return is guaranteed a free slot.
    assign credit_ok   = ({1'b0, count_q} + {1'b0, outst_q}) < DepthW;
    assign bus.mem_req = !reset && !bus.redirect && !halted_q && credit_ok;
    assign bus.mem_addr = pc_q;
    assign grant       = bus.mem_req && bus.mem_gnt;
    assign keep        = bus.mem_rvalid && (stale_q == '0);
    assign enq         = keep && !bus.redirect;

    assign bus.ir_valid = (count_q != '0);
    assign bus.ir       = q_data[rd_ptr_q];
    assign bus.ir_pc    = q_pc[rd_ptr_q];
    assign bus.halted   = halted_q;
    assign pop          = bus.ir_valid && bus.ir_ready;

    always_comb begin
        outst_d = outst_q;
        if (grant && !bus.mem_rvalid) begin
            outst_d = outst_q + CW'(1);
        end else if (!grant && bus.mem_rvalid) begin
            outst_d = outst_q - CW'(1);
        end

        pc_d     = grant ? pc_q + ADDRSIZE'(1) : pc_q;
        ret_pc_d = keep ? ret_pc_q + ADDRSIZE'(1) : ret_pc_q;
        wr_ptr_d = keep ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (keep && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!keep && pop) begin
            count_d = count_q - CW'(1);
        end

        stale_d = stale_q;
        if (bus.mem_rvalid && (stale_q != '0)) begin
            stale_d = stale_q - CW'(1);
        end

`ifdef FETCH_HALT_DETECT_EN
        halted_d = halted_q;
        if (is_hlt) begin
            // Everything still in flight after the HLT belongs to dead code.
            halted_d = 1'b1;
            stale_d  = outst_d;
        end
`endif

        if (bus.redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pc_d     = bus.redirect_pc;
            ret_pc_d = bus.redirect_pc;
            stale_d  = outst_d;
`ifdef FETCH_HALT_DETECT_EN
            halted_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            ret_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            outst_q  <= '0;
            stale_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            ret_pc_q <= ret_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            stale_q  <= stale_d;
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`endif

    // Queue storage needs no reset: count gates visibility.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_data[wr_ptr_q] <= bus.mem_rdata;
            q_pc[wr_ptr_q]   <= ret_pc_q;
        end
    end
endmodule
